// File: rtl/jtag_scan_master.sv
// jtag_scan_master: host-side JTAG scan engine.
// Runs one IR or DR scan of 1..DATA_W bits. It walks the target TAP from
// Run-Test/Idle through Capture, Shift, Exit1 and Update back to Run-Test/Idle,
// and returns the captured TDO bits. TCK runs at clk/2 while a scan is active.
// Optional feature: define JTAG_MASTER_TLR_RESET_EN to issue a Test-Logic-Reset
// sequence (five TMS=1 periods, then one TMS=0 period) after rst is released.
module jtag_scan_master #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_ir,
  input  logic [5:0]        len,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  localparam int IW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, TLR, PRE, SHIFT, POST, FIN} state_t;

  state_t            state;
  logic              ir;
  logic [IW-1:0]     nlast;   // scan length minus one, already clamped
  logic [IW-1:0]     bidx;    // current shift bit
  logic [1:0]        pstep;   // period index inside PRE / POST
  logic [DATA_W-1:0] sh;      // outgoing TDI bits, bit 0 is always the next one
  logic [DATA_W-1:0] cap;     // incoming TDO bits, placed at their bit index
`ifdef JTAG_MASTER_TLR_RESET_EN
  logic [2:0]        tstep;
`endif

  // Scan sequencer. Each TCK period is a low clk, which updates TMS/TDI,
  // followed by a high clk. TDO is sampled on the clk edge that raises TCK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef JTAG_MASTER_TLR_RESET_EN
      state <= TLR;
      busy  <= 1'b1;
      tstep <= 3'd0;
`else
      state <= IDLE;
      busy  <= 1'b0;
`endif
      TCK      <= 1'b0;
      TMS      <= 1'b1;
      TDI      <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      cap      <= '0;
      sh       <= '0;
      ir       <= 1'b0;
      nlast    <= '0;
      bidx     <= '0;
      pstep    <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          TCK <= 1'b0;
          TMS <= 1'b0;
          TDI <= 1'b0;
          if (start && !busy) begin
            ir    <= is_ir;
            nlast <= (int'(len) >= DATA_W) ? IW'(DATA_W - 1) : IW'(len);
            sh    <= data_in;
            cap   <= '0;
            busy  <= 1'b1;
            pstep <= 2'd0;
            TMS   <= 1'b1;  // first PRE period: Run-Test/Idle -> Select-DR
            state <= PRE;
          end
        end
`ifdef JTAG_MASTER_TLR_RESET_EN
        TLR: begin
          if (!TCK) begin
            TCK <= 1'b1;
          end else begin
            TCK <= 1'b0;
            if (tstep == 3'd5) begin
              busy  <= 1'b0;
              TMS   <= 1'b0;
              state <= IDLE;
            end else begin
              tstep <= tstep + 3'd1;
              TMS   <= (tstep != 3'd4);
            end
          end
        end
`endif
        PRE: begin
          if (!TCK) begin
            TCK <= 1'b1;
          end else begin
            TCK <= 1'b0;
            if (pstep == (ir ? 2'd3 : 2'd2)) begin
              bidx  <= '0;
              TMS   <= (nlast == '0);
              TDI   <= sh[0];
              state <= SHIFT;
            end else begin
              // DR: 1,0,0 ; IR: 1,1,0,0
              pstep <= pstep + 2'd1;
              TMS   <= ir && (pstep == 2'd0);
            end
          end
        end
        SHIFT: begin
          if (!TCK) begin
            TCK       <= 1'b1;
            cap[bidx] <= TDO;
          end else begin
            TCK <= 1'b0;
            if (bidx == nlast) begin
              pstep <= 2'd0;
              TMS   <= 1'b1;  // Exit1 -> Update
              TDI   <= 1'b0;
              state <= POST;
            end else begin
              bidx <= bidx + 1'b1;
              TDI  <= sh[1];
              sh   <= sh >> 1;
              TMS  <= ((bidx + 1'b1) == nlast);
            end
          end
        end
        POST: begin
          if (!TCK) begin
            TCK <= 1'b1;
          end else begin
            TCK <= 1'b0;
            TMS <= 1'b0;
            if (pstep == 2'd1) state <= FIN;
            else pstep <= 2'd1;
          end
        end
        FIN: begin
          data_out <= cap;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: random scans checked against a sequence-level
// reference model (TMS/TDI per TCK rise, latency, captured word).
module tb_jtag_scan_master;
  localparam int DW = 32;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, is_ir = 1'b0, TDO = 1'b0;
  logic [5:0]    len = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          busy, done, TCK, TMS, TDI;

  jtag_scan_master #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .is_ir(is_ir), .len(len),
    .data_in(data_in), .data_out(data_out), .busy(busy), .done(done),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 clk = ~clk;

  int          checks = 0, fails = 0, viol = 0;
  bit          tms_q[$], tdi_q[$];
  logic        tck_prev = 1'b0, tms_hi = 1'b0, tdi_hi = 1'b0;
  int          pre_n = 3;
  logic [63:0] pat = '0;

  // Target model: records TMS/TDI at every TCK rise and presents pattern bit
  // i on TDO ahead of the i-th shift rise (random junk outside the shift window).
  always @(negedge clk) begin
    if (TCK && !tck_prev) begin
      tms_q.push_back(TMS);
      tdi_q.push_back(TDI);
      tms_hi = TMS;
      tdi_hi = TDI;
    end else if (TCK && (TMS !== tms_hi || TDI !== tdi_hi)) begin
      viol++;
    end
    if (!rst && !busy && TCK) viol++;
    if (!TCK) begin
      int idx;
      idx = tms_q.size() - pre_n;
      TDO = (idx >= 0 && idx < 64) ? pat[idx] : 1'($urandom_range(0, 1));
    end
    tck_prev = TCK;
  end

  function automatic int neff(logic [5:0] l);
    return (int'(l) + 1 > DW) ? DW : int'(l) + 1;
  endfunction

  function automatic bit exp_tms(bit ir, int n, int i);
    int pre;
    pre = ir ? 4 : 3;
    if (i < pre) return ir ? (i <= 1) : (i == 0);
    if (i < pre + n) return (i == pre + n - 1);
    return (i == pre + n);
  endfunction

  function automatic bit exp_tdi(bit ir, int n, logic [63:0] din, int i);
    int pre;
    pre = ir ? 4 : 3;
    if (i >= pre && i < pre + n) return din[i - pre];
    return 1'b0;
  endfunction

  task automatic launch(bit ir, logic [5:0] l, logic [63:0] din, logic [63:0] p);
    @(negedge clk);
    is_ir = ir; len = l; data_in = din[DW-1:0]; pat = p; pre_n = ir ? 4 : 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tms_q.delete(); tdi_q.delete();
  endtask

  // Called #1 after the accept edge; returns #1 after the edge following done.
  task automatic check_scan(string nm, bit ir, int n, logic [63:0] din, logic [63:0] p);
    int cyc, nper, bad_tms, bad_tdi, lim;
    logic [63:0] mask, exp_do;
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_rise: got %b want 1", nm, busy); end
    cyc = 0;
    while (1) begin
      @(posedge clk); #1; cyc++;
      if (done === 1'b1 || cyc > 400) break;
    end
    nper = n + (ir ? 6 : 5);
    checks++;
    if (cyc !== 2 * nper + 1) begin fails++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, 2 * nper + 1); end
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    exp_do = p & mask;
    checks++;
    if (data_out !== exp_do[DW-1:0]) begin fails++; $display("FAIL %s data_out: got %h want %h", nm, data_out, exp_do[DW-1:0]); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL %s busy_fall: got %b want 0", nm, busy); end
    checks++;
    if (tms_q.size() !== nper) begin fails++; $display("FAIL %s tck_periods: got %0d want %0d", nm, tms_q.size(), nper); end
    bad_tms = 0; bad_tdi = 0;
    lim = (tms_q.size() < nper) ? tms_q.size() : nper;
    for (int i = 0; i < lim; i++) begin
      if (tms_q[i] !== exp_tms(ir, n, i)) bad_tms++;
      if (tdi_q[i] !== exp_tdi(ir, n, din, i)) bad_tdi++;
    end
    checks++;
    if (bad_tms !== 0) begin fails++; $display("FAIL %s tms_seq: got %0d wrong bits want 0", nm, bad_tms); end
    checks++;
    if (bad_tdi !== 0) begin fails++; $display("FAIL %s tdi_seq: got %0d wrong bits want 0", nm, bad_tdi); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL %s done_pulse: got %b want 0", nm, done); end
  endtask

  task automatic wait_ready();
`ifdef JTAG_MASTER_TLR_RESET_EN
    repeat (13) @(posedge clk);
`else
    repeat (2) @(posedge clk);
`endif
    #1;
  endtask

  task automatic check_reset_outputs(string nm);
    logic [4:0] exp;
`ifdef JTAG_MASTER_TLR_RESET_EN
    exp = 5'b01010;
`else
    exp = 5'b01000;
`endif
    checks++;
    if ({TCK, TMS, TDI, busy, done} !== exp) begin
      fails++; $display("FAIL %s ctrl: got %b want %b", nm, {TCK, TMS, TDI, busy, done}, exp);
    end
    checks++;
    if (data_out !== '0) begin fails++; $display("FAIL %s data_out: got %h want 0", nm, data_out); end
  endtask

  task automatic test_reset();
    int dones;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk);
    tms_q.delete(); tdi_q.delete();
    rst = 1'b0;
    dones = 0;
`ifdef JTAG_MASTER_TLR_RESET_EN
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done) dones++; end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL tlr busy_end: got %b want 0", busy); end
    checks++;
    if (tms_q.size() !== 6 || tms_q[0] !== 1 || tms_q[1] !== 1 || tms_q[2] !== 1 ||
        tms_q[3] !== 1 || tms_q[4] !== 1 || tms_q[5] !== 0) begin
      fails++; $display("FAIL tlr tms_seq: got %0d rises want 1,1,1,1,1,0", tms_q.size());
    end
`else
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (done) dones++; end
    checks++;
    if ({busy, TCK, TMS} !== 3'b000) begin fails++; $display("FAIL idle_after_reset: got %b want 000", {busy, TCK, TMS}); end
`endif
    checks++;
    if (dones !== 0) begin fails++; $display("FAIL reset no_done: got %0d want 0", dones); end
  endtask

  task automatic test_dr_loopback();
    launch(1'b0, 6'd7, 64'hA5, 64'hA5);
    check_scan("dr_a5", 1'b0, 8, 64'hA5, 64'hA5);
  endtask

  task automatic test_ir();
    launch(1'b1, 6'd3, 64'hE, '1);
    check_scan("ir_e", 1'b1, 4, 64'hE, '1);
  endtask

  task automatic test_clamp();
    logic [63:0] d, p;
    d = {$urandom, $urandom}; p = {$urandom, $urandom};
    launch(1'b0, 6'd63, d, p);
    check_scan("clamp", 1'b0, DW, d, p);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      bit ir;
      logic [5:0] l;
      logic [63:0] d, p;
      ir = 1'($urandom_range(0, 1));
      l = 6'($urandom_range(0, 63));
      d = {$urandom, $urandom}; p = {$urandom, $urandom};
      launch(ir, l, d, p);
      check_scan("random", ir, neff(l), d, p);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] da, pa, db, pb;
    da = {32'h0, $urandom}; pa = {$urandom, $urandom};
    db = {$urandom, $urandom}; pb = {$urandom, $urandom};
    @(negedge clk);
    is_ir = 1'b0; len = 6'd7; data_in = da[DW-1:0]; pat = pa; pre_n = 3; start = 1'b1;
    @(posedge clk); #1;
    tms_q.delete(); tdi_q.delete();
    is_ir = 1'b1; len = 6'd11; data_in = db[DW-1:0];  // start kept high all scan
    check_scan("b2b_first", 1'b0, 8, da, pa);
    start = 1'b0;
    tms_q.delete(); tdi_q.delete();
    pat = pb; pre_n = 4;
    check_scan("b2b_second", 1'b1, 12, db, pb);
  endtask

  task automatic test_rst_mid();
    int guard;
    logic [63:0] d, p;
    d = {$urandom, $urandom}; p = {$urandom, $urandom} | 64'h1;
    launch(1'b0, 6'd7, d, p);
    guard = 0;
    while (tms_q.size() < 7 && guard < 100) begin @(posedge clk); #2; guard++; end
    checks++;
    if (tms_q.size() !== 7) begin fails++; $display("FAIL rst_mid reach_bit4: got %0d rises want 7", tms_q.size()); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    wait_ready();
    d = {$urandom, $urandom}; p = {$urandom, $urandom};
    launch(1'b0, 6'd9, d, p);
    check_scan("after_rst", 1'b0, 10, d, p);
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin fails++; $display("FAIL pin_protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    wait_ready();
    test_dr_loopback();
    test_ir();
    test_clamp();
    test_random();
    test_back_to_back();
    test_rst_mid();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
